// File: rtl/matmul_sequencer.sv
// Start/busy/done sequencer for an 8x8 signed matrix multiply on an eight-lane MAC array.
// Build option: define MATMUL_SEQ_TRANSPOSE_EN to store C transposed (c_addr = j*8+i).
module matmul_sequencer #(
    parameter int DIM    = 8,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     a_addr,
    output logic [2:0]            b_row,
    output logic                  mac_en,
    output logic                  mac_first,
    input  logic [8*DATA_W-1:0]   mac_acc,
    output logic                  c_valid,
    input  logic                  c_ready,
    output logic [ADDR_W-1:0]     c_addr,
    output logic [DATA_W-1:0]     c_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_NEXT
    } state_t;

    localparam logic [2:0] LAST = 3'(DIM - 1);

    state_t      state_q;
    logic [2:0]  i_q;
    logic [2:0]  j_q;
    logic [2:0]  k_q;
    logic        busy_q;
    logic        done_q;
    logic        mac_en_q;
    logic        mac_first_q;
    logic        c_valid_q;

    logic [DATA_W-1:0] lane [DIM];

    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
        assign lane[gi] = mac_acc[gi*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            c_valid_q   <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            // Operand memories answer one cycle after the address, so the lane strobes trail FETCH.
            mac_en_q    <= (state_q == S_FETCH);
            mac_first_q <= (state_q == S_FETCH) && (k_q == 3'd0);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                    end
                end
                S_FETCH: begin
                    k_q <= k_q + 3'd1;
                    if (k_q == LAST) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    state_q   <= S_DRAIN;
                    j_q       <= '0;
                    c_valid_q <= 1'b1;
                end
                S_DRAIN: begin
                    if (c_ready) begin
                        j_q <= j_q + 3'd1;
                        if (j_q == LAST) begin
                            state_q   <= S_NEXT;
                            c_valid_q <= 1'b0;
                            if (i_q == LAST) begin
                                done_q <= 1'b1;
                                busy_q <= 1'b0;
                            end
                        end
                    end
                end
                S_NEXT: begin
                    if (i_q == LAST) begin
                        state_q <= S_IDLE;
                        i_q     <= '0;
                    end else begin
                        state_q <= S_FETCH;
                        i_q     <= i_q + 3'd1;
                        k_q     <= '0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mac_en    = mac_en_q;
    assign mac_first = mac_first_q;
    assign c_valid   = c_valid_q;
    assign a_addr    = {i_q, k_q};
    assign b_row     = k_q;
`ifdef MATMUL_SEQ_TRANSPOSE_EN
    assign c_addr    = {j_q, i_q};
`else
    assign c_addr    = {i_q, j_q};
`endif
    // Lanes hold while draining, so the selected lane is stable for the whole transfer.
    assign c_data    = c_valid_q ? lane[j_q] : '0;

endmodule
